// File: rtl/peak_result_framer_if.sv
// Bus bundle for the peak result framer: per-bin peak results and frame strobe in,
// 32-bit word stream (split into two 16-bit halves) with ready/valid handshake out.
interface peak_result_framer_if;
    logic        peak_valid_i;
    logic [31:0] peak_value_i;
    logic [9:0]  peak_addr_i;
    logic [4:0]  bin_index_i;
    logic [15:0] pulse_count_i;
    logic        frame_end_i;
    logic        ready_i;
    logic [15:0] y_hi_o;
    logic [15:0] y_lo_o;
    logic        word_valid_o;
    logic        busy_o;
    logic        overflow_o;

    modport slave (
        input  peak_valid_i, peak_value_i, peak_addr_i, bin_index_i,
        input  pulse_count_i, frame_end_i, ready_i,
        output y_hi_o, y_lo_o, word_valid_o, busy_o, overflow_o
    );

    modport master (
        output peak_valid_i, peak_value_i, peak_addr_i, bin_index_i,
        output pulse_count_i, frame_end_i, ready_i,
        input  y_hi_o, y_lo_o, word_valid_o, busy_o, overflow_o
    );
endinterface

// File: rtl/peak_result_framer.sv
// Collects per-range-bin peak results, then emits a framed word sequence
// (header, info, two words per bin, checksum trailer) over a ready/valid stream.
module peak_result_framer #(
    parameter int NOF_BINS = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    peak_result_framer_if.slave bus
);

    localparam int         IDX_W    = (NOF_BINS > 1) ? $clog2(NOF_BINS) : 1;
    localparam logic [5:0] NB       = 6'(NOF_BINS);
    localparam logic [4:0] LAST_BIN = 5'(NOF_BINS - 1);

    typedef enum logic [2:0] {
        COLLECT,
        HEADER,
        INFO,
        BIN_A,
        BIN_B,
        TRAILER
    } state_t;

    state_t              state_q;
    logic [NOF_BINS-1:0] valid_q;
    logic [9:0]          addr_q  [NOF_BINS];
    logic [31:0]         value_q [NOF_BINS];
    logic [4:0]          bin_q;
    logic [15:0]         frame_cnt_q;
    logic [15:0]         pulse_q;
    logic [15:0]         chk_q;
    logic [31:0]         word_q;
    logic                word_valid_q;
    logic                busy_q;
    logic                overflow_q;

    logic [4:0]          popcount;
    logic [15:0]         chk_next;
    logic [4:0]          bin_next;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    rd_idx_next;
    logic                slot_in_range;

    always_comb begin
        popcount = '0;
        for (int i = 0; i < NOF_BINS; i++) begin
            popcount = popcount + 5'(valid_q[i]);
        end
    end

    // Checksum including the word currently on the bus, used as it is accepted.
    assign chk_next      = chk_q ^ word_q[31:16] ^ word_q[15:0];
    assign bin_next      = bin_q + 5'd1;
    assign wr_idx        = bus.bin_index_i[IDX_W-1:0];
    assign rd_idx        = bin_q[IDX_W-1:0];
    assign rd_idx_next   = bin_next[IDX_W-1:0];
    assign slot_in_range = ({1'b0, bus.bin_index_i} < NB);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= COLLECT;
            valid_q      <= '0;
            for (int i = 0; i < NOF_BINS; i++) begin
                addr_q[i]  <= '0;
                value_q[i] <= '0;
            end
            bin_q        <= '0;
            frame_cnt_q  <= '0;
            pulse_q      <= '0;
            chk_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (bus.peak_valid_i) begin
                        if (slot_in_range) begin
                            valid_q[wr_idx] <= 1'b1;
                            addr_q[wr_idx]  <= bus.peak_addr_i;
                            value_q[wr_idx] <= bus.peak_value_i;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                    if (bus.frame_end_i) begin
                        pulse_q      <= bus.pulse_count_i;
                        chk_q        <= '0;
                        word_q       <= {16'hA5A5, frame_cnt_q};
                        word_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= HEADER;
                    end
                end
                default: begin
                    if (bus.peak_valid_i || bus.frame_end_i) begin
                        overflow_q <= 1'b1;
                    end
                    if (bus.ready_i) begin
                        chk_q <= chk_next;
                        case (state_q)
                            HEADER: begin
                                word_q  <= {pulse_q, 11'b0, popcount};
                                state_q <= INFO;
                            end
                            INFO: begin
                                bin_q   <= '0;
                                word_q  <= {valid_q[0], 5'd0, addr_q[0], 16'h0000};
                                state_q <= BIN_A;
                            end
                            BIN_A: begin
                                word_q  <= value_q[rd_idx];
                                state_q <= BIN_B;
                            end
                            BIN_B: begin
                                if (bin_q == LAST_BIN) begin
                                    word_q  <= {16'h5A5A, chk_next};
                                    state_q <= TRAILER;
                                end else begin
                                    bin_q   <= bin_next;
                                    word_q  <= {valid_q[rd_idx_next], bin_next,
                                                addr_q[rd_idx_next], 16'h0000};
                                    state_q <= BIN_A;
                                end
                            end
                            TRAILER: begin
                                // Frame handed off: start the next collection from empty slots.
                                valid_q <= '0;
                                for (int i = 0; i < NOF_BINS; i++) begin
                                    addr_q[i]  <= '0;
                                    value_q[i] <= '0;
                                end
                                frame_cnt_q  <= frame_cnt_q + 16'd1;
                                word_q       <= '0;
                                word_valid_q <= 1'b0;
                                busy_q       <= 1'b0;
                                state_q      <= COLLECT;
                            end
                            default: state_q <= COLLECT;
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.y_hi_o       = word_q[31:16];
    assign bus.y_lo_o       = word_q[15:0];
    assign bus.word_valid_o = word_valid_q;
    assign bus.busy_o       = busy_q;
    assign bus.overflow_o   = overflow_q;

endmodule

// File: tb/tb_peak_result_framer.sv
// Self-checking bench for peak_result_framer: a frame-level model builds each expected
// word sequence from the slot contents; a negedge process compares the DUT every cycle.
module tb_peak_result_framer;

    localparam int NOF_BINS    = 16;
    localparam int FRAME_WORDS = 3 + 2 * NOF_BINS;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    peak_result_framer_if bus ();

    peak_result_framer #(.NOF_BINS(NOF_BINS)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic        m_valid [NOF_BINS];
    logic [9:0]  m_addr  [NOF_BINS];
    logic [31:0] m_value [NOF_BINS];
    logic [15:0] m_frame_cnt = '0;
    logic        m_ovf       = 1'b0;
    logic [31:0] m_popped;
    logic        cmp_busy;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelClearSlots();
        for (int i = 0; i < NOF_BINS; i++) begin
            m_valid[i] = 1'b0;
            m_addr[i]  = '0;
            m_value[i] = '0;
        end
    endtask

    // Whole frame computed at the frame-end strobe straight from the word layout rules.
    task automatic modelBuildFrame(input logic [15:0] pulse_count);
        logic [31:0] words[$];
        logic [15:0] chk;
        int          pop;
        pop = 0;
        for (int b = 0; b < NOF_BINS; b++) pop += m_valid[b] ? 1 : 0;
        words.push_back({16'hA5A5, m_frame_cnt});
        words.push_back({pulse_count, 11'b0, 5'(pop)});
        for (int b = 0; b < NOF_BINS; b++) begin
            words.push_back({m_valid[b], 5'(b), m_valid[b] ? m_addr[b] : 10'd0, 16'h0000});
            words.push_back(m_valid[b] ? m_value[b] : 32'd0);
        end
        chk = '0;
        foreach (words[i]) chk = chk ^ words[i][31:16] ^ words[i][15:0];
        words.push_back({16'h5A5A, chk});
        foreach (words[i]) exp_q.push_back(words[i]);
    endtask

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exp_q.delete();
            m_frame_cnt = '0;
            m_ovf       = 1'b0;
            modelClearSlots();
        end else if (exp_q.size() != 0) begin
            if (bus.peak_valid_i || bus.frame_end_i) m_ovf = 1'b1;
            if (bus.ready_i) begin
                m_popped = exp_q.pop_front();
                if (exp_q.size() == 0) begin
                    modelClearSlots();
                    m_frame_cnt = m_frame_cnt + 16'd1;
                end
            end
        end else begin
            if (bus.peak_valid_i) begin
                if (int'(bus.bin_index_i) < NOF_BINS) begin
                    m_valid[int'(bus.bin_index_i)] = 1'b1;
                    m_addr[int'(bus.bin_index_i)]  = bus.peak_addr_i;
                    m_value[int'(bus.bin_index_i)] = bus.peak_value_i;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (bus.frame_end_i) modelBuildFrame(bus.pulse_count_i);
        end
    end

    always @(negedge clk_i) begin
        cmp_busy = (exp_q.size() != 0);
        checkOutput("word_valid", 32'(bus.word_valid_o), 32'(cmp_busy));
        checkOutput("busy", 32'(bus.busy_o), 32'(cmp_busy));
        checkOutput("overflow", 32'(bus.overflow_o), 32'(m_ovf));
        if (cmp_busy) checkOutput("word", {bus.y_hi_o, bus.y_lo_o}, exp_q[0]);
        if (rst_i) checkOutput("reset_word", {bus.y_hi_o, bus.y_lo_o}, 32'h0);
        if (bus.word_valid_o && bus.ready_i && !rst_i) obs_q.push_back({bus.y_hi_o, bus.y_lo_o});
    end

    task automatic applyStimulus(input logic pv, input logic [4:0] bin, input logic [9:0] addr,
                                 input logic [31:0] value, input logic fe,
                                 input logic [15:0] pulse_count);
        bus.peak_valid_i  = pv;
        bus.bin_index_i   = bin;
        bus.peak_addr_i   = addr;
        bus.peak_value_i  = value;
        bus.frame_end_i   = fe;
        bus.pulse_count_i = pulse_count;
        @(posedge clk_i);
        #1;
        bus.peak_valid_i = 1'b0;
        bus.frame_end_i  = 1'b0;
    endtask

    task automatic drainFrame(input bit random_ready);
        int cycles;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 2000) begin
            bus.ready_i = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk_i);
            #1;
            cycles++;
        end
        bus.ready_i = 1'b1;
        checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        int cycles;
        bus.peak_valid_i  = 1'b0;
        bus.peak_value_i  = '0;
        bus.peak_addr_i   = '0;
        bus.bin_index_i   = '0;
        bus.pulse_count_i = '0;
        bus.frame_end_i   = 1'b0;
        bus.ready_i       = 1'b1;
        doReset();
        checkOutput("rst_valid", 32'(bus.word_valid_o), 32'd0);
        checkOutput("rst_overflow", 32'(bus.overflow_o), 32'd0);

        $display("[TB] empty frame");
        obs_q.delete();
        applyStimulus(1'b0, 5'd0, 10'd0, 32'd0, 1'b1, 16'd100);
        drainFrame(1'b0);
        checkOutput("t1_count", 32'(obs_q.size()), 32'(FRAME_WORDS));
        checkOutput("t1_header", obs_q[0], 32'hA5A5_0000);
        checkOutput("t1_info", obs_q[1], 32'h0064_0000);
        checkOutput("t1_bin0a", obs_q[2], 32'h0000_0000);
        checkOutput("t1_bin1a", obs_q[4], 32'h0400_0000);
        checkOutput("t1_trailer", obs_q[34], 32'h5A5A_A5C1);

        $display("[TB] repeated peak in bin 3");
        applyStimulus(1'b1, 5'd3, 10'h012, 32'h0001_0000, 1'b0, 16'd0);
        applyStimulus(1'b1, 5'd3, 10'h020, 32'h0000_0055, 1'b0, 16'd0);
        obs_q.delete();
        applyStimulus(1'b0, 5'd0, 10'd0, 32'd0, 1'b1, 16'd200);
        drainFrame(1'b0);
        checkOutput("t2_header", obs_q[0], 32'hA5A5_0001);
        checkOutput("t2_info", obs_q[1], 32'h00C8_0001);
        checkOutput("t2_bin2a", obs_q[6], 32'h0800_0000);
        checkOutput("t2_bin3a", obs_q[8], 32'h8C20_0000);
        checkOutput("t2_bin3b", obs_q[9], 32'h0000_0055);

        $display("[TB] strobes while busy");
        obs_q.delete();
        applyStimulus(1'b0, 5'd0, 10'd0, 32'd0, 1'b1, 16'd7);
        applyStimulus(1'b1, 5'd5, 10'h3FF, 32'hDEAD_BEEF, 1'b1, 16'd9);
        checkOutput("t3_ovf_busy", 32'(bus.overflow_o), 32'd1);
        drainFrame(1'b0);
        checkOutput("t3_header", obs_q[0], 32'hA5A5_0002);
        checkOutput("t3_info", obs_q[1], 32'h0007_0000);
        checkOutput("t3_bin5a", obs_q[12], 32'h1400_0000);
        checkOutput("t3_ovf_sticky", 32'(bus.overflow_o), 32'd1);

        $display("[TB] out-of-range bin");
        doReset();
        checkOutput("t4_ovf_cleared", 32'(bus.overflow_o), 32'd0);
        applyStimulus(1'b1, 5'd20, 10'h001, 32'h1234_5678, 1'b0, 16'd0);
        checkOutput("t4_ovf_range", 32'(bus.overflow_o), 32'd1);

        $display("[TB] peak together with frame end");
        doReset();
        obs_q.delete();
        applyStimulus(1'b1, 5'd0, 10'h155, 32'hCAFE_F00D, 1'b1, 16'd1);
        drainFrame(1'b0);
        checkOutput("t5_header", obs_q[0], 32'hA5A5_0000);
        checkOutput("t5_info", obs_q[1], 32'h0001_0001);
        checkOutput("t5_bin0a", obs_q[2], 32'h8155_0000);
        checkOutput("t5_bin0b", obs_q[3], 32'hCAFE_F00D);

        $display("[TB] reset mid-frame");
        obs_q.delete();
        applyStimulus(1'b0, 5'd0, 10'd0, 32'd0, 1'b1, 16'd9);
        cycles = 0;
        while (obs_q.size() < 10 && cycles < 100) begin
            @(posedge clk_i);
            #1;
            cycles++;
        end
        checkOutput("t6_reached", 32'(obs_q.size()), 32'd10);
        checkOutput("t6_header", obs_q[0], 32'hA5A5_0001);
        rst_i = 1'b1;
        #1;
        checkOutput("t6_abort_word", {bus.y_hi_o, bus.y_lo_o}, 32'h0);
        checkOutput("t6_abort_valid", 32'(bus.word_valid_o), 32'd0);
        checkOutput("t6_abort_busy", 32'(bus.busy_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        $display("[TB] backpressure frame");
        obs_q.delete();
        applyStimulus(1'b0, 5'd0, 10'd0, 32'd0, 1'b1, 16'd100);
        drainFrame(1'b1);
        checkOutput("t7_count", 32'(obs_q.size()), 32'(FRAME_WORDS));
        checkOutput("t7_header", obs_q[0], 32'hA5A5_0000);
        checkOutput("t7_info", obs_q[1], 32'h0064_0000);
        checkOutput("t7_trailer", obs_q[34], 32'h5A5A_A5C1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/peak_result_framer.md
PEAK_RESULT_FRAMER -- requirements
Module: peak_result_framer

Interface
REQ-001 Parameter NOF_BINS, default 16: number of range-bin result slots (1..31).
REQ-002 clk_i  input  1  clock; all logic is rising-edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 peak_valid_i  input  1  one-cycle strobe; a per-bin peak result is present.
REQ-005 peak_value_i  input  32  peak power value (unsigned).
REQ-006 peak_addr_i  input  10  spectral line index of the peak.
REQ-007 bin_index_i  input  5  range-bin number of the result.
REQ-008 pulse_count_i  input  16  accumulated pulse count for the frame; sampled at frame end.
REQ-009 frame_end_i  input  1  one-cycle strobe; peak detection for all bins is complete.
REQ-010 ready_i  input  1  downstream accepts the current word.
REQ-011 y_hi_o  output  16  bits [31:16] of the output word.
REQ-012 y_lo_o  output  16  bits [15:0] of the output word.
REQ-013 word_valid_o  output  1  y_hi_o/y_lo_o carry a valid word.
REQ-014 busy_o  output  1  a frame is being emitted.
REQ-015 overflow_o  output  1  sticky error flag.

Function
REQ-016 States: COLLECT, HEADER, INFO, BIN_A, BIN_B, TRAILER; the block leaves reset in COLLECT.
REQ-017 In COLLECT, peak_valid_i with bin_index_i < NOF_BINS stores {peak_value_i, peak_addr_i} into slot bin_index_i and sets that slot's valid bit; a repeat write to the same slot overwrites it (last wins).
REQ-018 peak_valid_i with bin_index_i >= NOF_BINS is discarded and sets overflow_o.
REQ-019 frame_end_i in COLLECT latches pulse_count_i and moves to HEADER; if peak_valid_i is high in the same cycle, that entry is stored and included in the frame.
REQ-020 Latency: with frame_end_i high in cycle t, word_valid_o=1 with the header word in cycle t+1.
REQ-021 Handshake: the output word and word_valid_o are registered and held stable until the cycle ready_i=1; the next word appears in the following cycle; back-to-back words are produced while ready_i stays high.
REQ-022 Header word = {16'hA5A5, frame_cnt[15:0]}; frame_cnt is an internal counter, reset 0, incremented when the trailer is accepted, and it wraps 16'hFFFF->0.
REQ-023 Info word = {latched pulse count[15:0], 11'b0, popcount of slot valid bits[4:0]}.
REQ-024 For b = 0..NOF_BINS-1 in ascending order, emit BIN_A = {valid[b], b[4:0], addr[b][9:0], 16'h0000}, then BIN_B = value[b][31:0]; invalid slots emit addr=0 and value=0.
REQ-025 Trailer word = {16'h5A5A, chk}, where chk = XOR of every 16-bit half of all preceding words in the frame.
REQ-026 A frame is therefore exactly 3 + 2*NOF_BINS words (35 for NOF_BINS=16).
REQ-027 When the trailer is accepted: clear all slot valid bits and slot contents, increment frame_cnt, deassert word_valid_o and busy_o in the next cycle, and return to COLLECT.
REQ-028 busy_o = 1 in every state except COLLECT.
REQ-029 While not in COLLECT, peak_valid_i and frame_end_i are ignored and each sets overflow_o; slot contents and the emitted frame are unaffected.
REQ-030 overflow_o is sticky and is cleared only by reset.

Reset
REQ-031 During reset: word_valid_o=0, busy_o=0, overflow_o=0, y_hi_o=y_lo_o=0, frame_cnt=0, all slots and valid bits cleared, state=COLLECT.
REQ-032 Reset asserted mid-frame aborts emission immediately; no trailer is produced, and the first frame after reset has frame_cnt=0.

Verification
REQ-033 Empty frame: pulse_count_i=100, frame_end_i pulse, ready_i=1 -> 35 consecutive words: A5A5_0000, 0064_0000, all bin words with valid=0, trailer 5A5A_A5C1.
REQ-034 Peaks: bin 3 (addr 0x12, value 0x0001_0000) and bin 3 again (addr 0x20, value 0x55) -> BIN_A(3)=0x8C20_0000, BIN_B(3)=0x0000_0055, info popcount=1.
REQ-035 Backpressure: toggle ready_i randomly -> each word is held stable while ready_i=0; no word is lost or duplicated; the sequence matches REQ-033.
REQ-036 Overflow: bin_index_i=20 in COLLECT, or frame_end_i while busy_o=1 -> overflow_o=1 and stays 1; the current frame is unchanged.
REQ-037 Simultaneous peak_valid_i (bin 0) and frame_end_i -> bin 0 is valid in that frame; the next frame header is A5A5_0001.
REQ-038 Reset at word 10 of a frame -> outputs go to 0 at once; the next frame header is A5A5_0000.
